// File: rtl/rot_imm_encoder_pkg.sv
// Shared types and constants for the rotated-immediate encoder.
// Also holds the helper that tests whether a candidate fits the immediate field.
package rot_imm_encoder_pkg;

    localparam int ROT_STEPS = 16;
    localparam int IMM_W     = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEARCH     = 2'd1,
        SEARCH_INV = 2'd2,
        DONE       = 2'd3
    } state_t;

    // A candidate is encodable when everything above the immediate field is zero.
    function automatic logic fits_imm(input logic [31:0] cand);
        return (cand[31:IMM_W] == {(32-IMM_W){1'b0}});
    endfunction

endpackage

// File: rtl/rot_imm_encoder_rot_left.sv
// Combinational 32-bit rotate-left by a 5-bit amount.
module rot_left (
    input  logic [31:0] i_data,
    input  logic [4:0]  i_amt,
    output logic [31:0] o_data
);

    logic [63:0] w_dbl;

    // The upper half of a doubled word shifted left is the rotation.
    assign w_dbl  = {i_data, i_data} << i_amt;
    assign o_data = w_dbl[63:32];

endmodule

// File: rtl/rot_imm_encoder.sv
// Searches for the {rot, imm8} pair whose rotate-right reproduces a 32-bit value,
// optionally retrying on the complement of the value.
module rot_imm_encoder
    import rot_imm_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    input  logic        allow_inv,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic        inv,
    output logic [3:0]  rot,
    output logic [7:0]  imm8
);

    state_t      r_state;
    logic [3:0]  r_rot_cnt;
    logic [31:0] r_value;
    logic        r_allow_inv;
    logic        r_busy;
    logic        r_done;
    logic        r_found;
    logic        r_inv;
    logic [3:0]  r_rot;
    logic [7:0]  r_imm8;

    logic [31:0] w_src;
    logic [31:0] w_cand;
    logic        w_hit;
    logic        w_last;

    assign w_src  = (r_state == SEARCH_INV) ? ~r_value : r_value;
    assign w_hit  = fits_imm(w_cand);
    assign w_last = (r_rot_cnt == 4'(ROT_STEPS - 1));

    rot_left u_rot_left (
        .i_data (w_src),
        .i_amt  ({r_rot_cnt, 1'b0}),
        .o_data (w_cand)
    );

    // Search FSM with counter, input latches and registered result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rot_cnt   <= 4'd0;
            r_value     <= 32'd0;
            r_allow_inv <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_found     <= 1'b0;
            r_inv       <= 1'b0;
            r_rot       <= 4'd0;
            r_imm8      <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state     <= SEARCH;
                        r_value     <= value;
                        r_allow_inv <= allow_inv;
                        r_rot_cnt   <= 4'd0;
                        r_busy      <= 1'b1;
                        r_found     <= 1'b0;
                        r_inv       <= 1'b0;
                        r_rot       <= 4'd0;
                        r_imm8      <= 8'd0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SEARCH, SEARCH_INV: begin
                    if (w_hit) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_found <= 1'b1;
                        r_inv   <= (r_state == SEARCH_INV);
                        r_rot   <= r_rot_cnt;
                        r_imm8  <= w_cand[IMM_W-1:0];
                    end else if (w_last) begin
                        r_rot_cnt <= 4'd0;
                        // Only the plain pass may fall through to the complement pass.
                        if ((r_state == SEARCH) && r_allow_inv) begin
                            r_state <= SEARCH_INV;
                        end else begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_found <= 1'b0;
                            r_inv   <= 1'b0;
                            r_rot   <= 4'd0;
                            r_imm8  <= 8'd0;
                        end
                    end else begin
                        r_rot_cnt <= r_rot_cnt + 4'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_rot_cnt <= 4'd0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign found = r_found;
    assign inv   = r_inv;
    assign rot   = r_rot;
    assign imm8  = r_imm8;

endmodule

// File: doc/rot_imm_encoder.md
# rot_imm_encoder

Multi-cycle encoder that finds the ARM data-processing immediate form (imm8 rotated right by 2·rot) of a 32-bit constant. It is the inverse of the datapath shifter's rotate-right path. The shifter expands {rot, imm8} into a 32-bit operand; this block searches for the {rot, imm8} pair that reproduces a given value, optionally also trying the bitwise complement (MVN/CMN-style form). It sits beside the decode/assembler-support logic and is driven by a start/done handshake.

## Interface
- No parameters; rotation count fixed at 16 steps (package constant).
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: request; sampled only in IDLE.
- `value` input 32: constant to encode; latched on accepted start.
- `allow_inv` input 1: if 1, search ~value after value fails; latched on accepted start.
- `busy` output 1: high in SEARCH and SEARCH_INV.
- `done` output 1: one-cycle pulse when result is valid.
- `found` output 1: encoding exists.
- `inv` output 1: encoding applies to ~value.
- `rot` output 4: rotation field; operand = ROR(imm8, 2·rot).
- `imm8` output 8: immediate field.

## Operation
- States: IDLE, SEARCH, SEARCH_INV, DONE.
- IDLE: if `start`, latch `value` and `allow_inv`, clear `rot_cnt`, and go to SEARCH. Otherwise stay.
- SEARCH: each cycle forms cand = ROL(value_q, 2·rot_cnt), with the shift taken modulo 32.
  - If cand[31:8]==0: register found=1, inv=0, rot=rot_cnt, imm8=cand[7:0], and go to DONE.
  - Else if rot_cnt==15: if allow_inv_q, clear rot_cnt and go to SEARCH_INV; otherwise register found=0, rot=0, imm8=0 and go to DONE.
  - Else rot_cnt+1.
- SEARCH_INV: same as SEARCH on ~value_q.
  - On a match: found=1, inv=1.
  - On exhaustion: found=0, inv=0, rot=0, imm8=0, and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Smallest rot wins; the non-inverted form always beats the inverted form.
- value 0 encodes as rot=0, imm8=0.
- found/inv/rot/imm8 hold their values from DONE until the next accepted start, then clear to 0 on that start.
- `start` in any state other than IDLE is ignored. This includes DONE, so there is no back-to-back acceptance.
- Reset at any time: state=IDLE, rot_cnt=0. All outputs go to 0 immediately, because reset is asynchronous.

## Timing
- Start sampled at edge E0 moves the FSM to SEARCH.
- Match at rot k, non-inverted: DONE is entered at E(k+1). `done` is high from E(k+1) to E(k+2).
- Non-inverted failure with allow_inv=0: done from E16.
- Inverted match at k: done from E(17+k).
- Full failure with allow_inv=1: done from E32.
- Worst-case latency is 32 cycles. Next start can be accepted at E(done+1) at the earliest.
- All outputs are registered. There is no combinational path from the inputs to any output.

## Structure
- Shared package holds:
  - state enum (IDLE, SEARCH, SEARCH_INV, DONE);
  - ROT_STEPS=16;
  - IMM_W=8.
- Sub-module `rot_left`: combinational 32-bit rotate-left by a 5-bit amount. It takes {rot_cnt,1'b0} and is instantiated once, with a mux selecting value_q or ~value_q.
- Top block holds the FSM, rot_cnt, input latches and result registers.

## Test plan
- value=0x000000FF, allow_inv=0 -> found=1, inv=0, rot=0, imm8=0xFF; done from E1.
- value=0xF000000F -> found=1, rot=2, imm8=0xFF; done from E3. value=0xFF000000 -> rot=4, imm8=0xFF; done from E5.
- value=0x00000102, allow_inv=0 -> found=0, rot=0, imm8=0; done from E16. Same value with allow_inv=1 -> found=0; done from E32.
- value=0xFFFFFF00, allow_inv=1 -> found=1, inv=1, rot=0, imm8=0xFF; done from E17. With allow_inv=0 -> found=0 at E16.
- Start 0xFF000000, pulse start with 0x000000FF at E2 -> second start ignored; result rot=4 at E5.
- Assert reset at E3 of a 0x00000102 search -> busy, done and outputs are 0 immediately. Start 0x000000FF after release -> correct result at E1 relative to that start.
